dbo_wr_drv: RTL and testbench
=============================

Name: dbo_wr_drv

Overview:
- Data-bus write driver for the m6502 model: the output-side counterpart of the 8-bit load register.
- Captures a byte from the internal data path on a write request.
- Sequences R/W and output enable onto the external data bus through setup, drive (stallable by rdy) and hold phases.
- Acknowledges the requester when the transfer completes.

Parameters:
- DW, 8: data width.
- HOLD_CYC, 1: cycles data stays driven after rw_n returns high (0..15).
- TIMEOUT, 255: maximum DRIVE cycles with rdy low before abort (1..255). Used only with DBO_WDOG_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- res_n  in  1  asynchronous active-low reset.
- wr_req  in  1  write request; sampled only in IDLE.
- wr_di  in  DW  data to write; captured on the accepting edge.
- rdy  in  1  external ready; high completes the DRIVE phase.
- wr_ack  out  1  one-cycle pulse: transfer completed.
- err  out  1  one-cycle pulse: transfer aborted by watchdog. Constant 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- db_o  out  DW  external data bus output value.
- db_oe  out  1  external data bus output enable.
- rw_n  out  1  bus direction: 1 = read/idle, 0 = write.

Behaviour:
- Reset (res_n low, async, immediate, regardless of state):
  - state IDLE.
  - db_o = 0, db_oe = 0, rw_n = 1, wr_ack = 0, err = 0, busy = 0.
  - hold counter 0, watchdog counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, DRIVE, HOLD.
- IDLE:
  - db_oe = 0, rw_n = 1, busy = 0.
  - wr_req = 1 at an edge: data register <= wr_di, go to SETUP.
- SETUP (exactly 1 cycle):
  - rw_n = 0, db_oe = 0, db_o = latched data.
  - Next state DRIVE.
- DRIVE:
  - rw_n = 0, db_oe = 1.
  - rdy = 0: remain in DRIVE.
  - rdy = 1 at an edge: wr_ack = 1 for the following cycle. Go to HOLD with counter = HOLD_CYC, or to IDLE if HOLD_CYC = 0.
- HOLD:
  - rw_n = 1, db_oe = 1, db_o unchanged.
  - Counter decrements each cycle; on reaching 1, next state is IDLE.
  - HOLD lasts exactly HOLD_CYC cycles.
- db_o retains the last written value after the transfer; it is not cleared in IDLE.
- wr_req outside IDLE is ignored, with no queueing. The requester must hold wr_req until busy falls, then re-present it.
- wr_di changes after the accepting edge have no effect on the transfer in flight.
- Minimum spacing: one IDLE cycle between transfers. Latency from accepting edge to wr_ack = 2 + (number of rdy-low DRIVE cycles) cycles.
- wr_ack and err are mutually exclusive and never asserted in the same cycle.
- Reset mid-transfer: bus released in the same instant (db_oe = 0, rw_n = 1). No wr_ack or err is issued for the aborted transfer.

Optional Feature:
- Macro: DBO_WDOG_EN.
- Defined:
  - An 8-bit watchdog counter clears on entry to DRIVE and increments each DRIVE cycle with rdy = 0.
  - If it reaches TIMEOUT, the next state is IDLE, err pulses 1 cycle, and no wr_ack is issued.
  - rdy = 1 on the same edge the count reaches TIMEOUT: rdy wins and the transfer completes normally.
- Not defined:
  - No watchdog logic; err is tied 0.
  - DRIVE waits indefinitely for rdy.

Test Plan:
- Reset values: assert res_n low mid-DRIVE (db_oe = 1) -> db_oe = 0, rw_n = 1, busy = 0, db_o = 0 immediately, without waiting for clk.
- Basic write: HOLD_CYC = 1, wr_di = 0xA5, wr_req pulse, rdy tied 1 -> SETUP 1 cycle (rw_n = 0, db_oe = 0), DRIVE 1 cycle (db_o = 0xA5, db_oe = 1), wr_ack in the HOLD cycle, busy low 3 cycles after the accepting edge.
- Wait states: rdy low for 4 DRIVE cycles, then high -> DRIVE lasts 5 cycles, one wr_ack, db_o stable at the latched value throughout.
- Ignored request and data stability: wr_req = 1 with wr_di = 0x3C during DRIVE of a 0x5A transfer -> 0x5A completes. 0x3C is accepted only on the first IDLE edge after busy falls.
- Zero hold: HOLD_CYC = 0 -> DRIVE goes straight to IDLE, db_oe and rw_n return to 0/1 together, and db_o keeps its value.
- Watchdog (DBO_WDOG_EN, TIMEOUT = 3): rdy held 0 -> abort after 3 rdy-low DRIVE cycles, err = 1 one cycle, wr_ack never seen. Repeat with rdy = 1 on the 3rd cycle -> wr_ack and no err.

Source files
------------

// File: rtl/dbo_wr_if.sv
// Bus bundle between a write requester / external bus model and the dbo_wr_drv write driver.
interface dbo_wr_if #(
    parameter int unsigned DW = 8
);
    logic          wr_req;
    logic [DW-1:0] wr_di;
    logic          rdy;
    logic          wr_ack;
    logic          err;
    logic          busy;
    logic [DW-1:0] db_o;
    logic          db_oe;
    logic          rw_n;

    modport master (
        output wr_req, wr_di, rdy,
        input  wr_ack, err, busy, db_o, db_oe, rw_n
    );

    modport slave (
        input  wr_req, wr_di, rdy,
        output wr_ack, err, busy, db_o, db_oe, rw_n
    );
endinterface

// File: rtl/dbo_wr_drv.sv
// m6502 data-bus write driver: SETUP -> DRIVE (rdy-stallable) -> HOLD sequencing of rw_n/db_oe.
// Optional watchdog abort on a stuck rdy is enabled by defining DBO_WDOG_EN.
module dbo_wr_drv #(
    parameter int unsigned DW       = 8,
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic     clk,
    input  logic     res_n,
    dbo_wr_if.slave  bus
);
    localparam int unsigned HCW = 4;
    localparam int unsigned WDW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRIVE,
        S_HOLD
    } state_t;

    if (HOLD_CYC > 15) begin : g_bad_hold
        $error("dbo_wr_drv: HOLD_CYC must be 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dbo_wr_drv: TIMEOUT must be 1..255");
    end

    state_t         state_q, state_d;
    logic [DW-1:0]  db_o_q, db_o_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic           db_oe_q, db_oe_d;
    logic           rw_n_q, rw_n_d;
    logic           busy_q, busy_d;
    logic           wr_ack_q, wr_ack_d;
    logic           err_q, err_d;
`ifdef DBO_WDOG_EN
    logic [WDW-1:0] wd_q, wd_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= S_IDLE;
            db_o_q   <= '0;
            hcnt_q   <= '0;
            db_oe_q  <= 1'b0;
            rw_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef DBO_WDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            db_o_q   <= db_o_d;
            hcnt_q   <= hcnt_d;
            db_oe_q  <= db_oe_d;
            rw_n_q   <= rw_n_d;
            busy_q   <= busy_d;
            wr_ack_q <= wr_ack_d;
            err_q    <= err_d;
`ifdef DBO_WDOG_EN
            wd_q     <= wd_d;
`endif
        end
    end

    // Next state; bus controls are decoded from the next state so they register cleanly
    always_comb begin
        state_d  = state_q;
        db_o_d   = db_o_q;
        hcnt_d   = hcnt_q;
        wr_ack_d = 1'b0;
        err_d    = 1'b0;
`ifdef DBO_WDOG_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.wr_req) begin
                    db_o_d  = bus.wr_di;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_DRIVE;
`ifdef DBO_WDOG_EN
                wd_d    = '0;
`endif
            end
            S_DRIVE: begin
                if (bus.rdy) begin
                    wr_ack_d = 1'b1;
                    if (HOLD_CYC == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        hcnt_d  = HCW'(HOLD_CYC);
                    end
                end
`ifdef DBO_WDOG_EN
                else begin
                    wd_d = wd_q + WDW'(1);
                    if (wd_d == WDW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            S_HOLD: begin
                hcnt_d = hcnt_q - HCW'(1);
                if (hcnt_q <= HCW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        rw_n_d  = !((state_d == S_SETUP) || (state_d == S_DRIVE));
        db_oe_d = (state_d == S_DRIVE) || (state_d == S_HOLD);
    end

    assign bus.db_o   = db_o_q;
    assign bus.db_oe  = db_oe_q;
    assign bus.rw_n   = rw_n_q;
    assign bus.busy   = busy_q;
    assign bus.wr_ack = wr_ack_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_dbo_wr_drv.sv
// Directed bench for dbo_wr_drv: instance a has HOLD_CYC=1, instance b has HOLD_CYC=0 and TIMEOUT=3.
module tb_dbo_wr_drv;
    logic clk = 1'b0;
    logic res_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dbo_wr_if #(.DW(8)) a_if ();
    dbo_wr_if #(.DW(8)) b_if ();

    dbo_wr_drv #(.DW(8), .HOLD_CYC(1), .TIMEOUT(255)) u_a (
        .clk   (clk),
        .res_n (res_n),
        .bus   (a_if)
    );

    dbo_wr_drv #(.DW(8), .HOLD_CYC(0), .TIMEOUT(3)) u_b (
        .clk   (clk),
        .res_n (res_n),
        .bus   (b_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        res_n = 1'b0;
        a_if.wr_req = 1'b0; a_if.wr_di = 8'h00; a_if.rdy = 1'b0;
        b_if.wr_req = 1'b0; b_if.wr_di = 8'h00; b_if.rdy = 1'b0;
        tick(); tick();
        chk("rst_db_o",   32'(a_if.db_o),   32'h00);
        chk("rst_db_oe",  32'(a_if.db_oe),  32'h0);
        chk("rst_rw_n",   32'(a_if.rw_n),   32'h1);
        chk("rst_busy",   32'(a_if.busy),   32'h0);
        chk("rst_wr_ack", 32'(a_if.wr_ack), 32'h0);
        chk("rst_err",    32'(a_if.err),    32'h0);
        res_n = 1'b1;
        tick();

        // Basic write, rdy tied high
        a_if.wr_di = 8'hA5; a_if.wr_req = 1'b1; a_if.rdy = 1'b1;
        tick();
        a_if.wr_req = 1'b0;
        chk("basic_setup_rw_n",  32'(a_if.rw_n),   32'h0);
        chk("basic_setup_oe",    32'(a_if.db_oe),  32'h0);
        chk("basic_setup_busy",  32'(a_if.busy),   32'h1);
        chk("basic_setup_ack",   32'(a_if.wr_ack), 32'h0);
        tick();
        chk("basic_drive_rw_n",  32'(a_if.rw_n),   32'h0);
        chk("basic_drive_oe",    32'(a_if.db_oe),  32'h1);
        chk("basic_drive_db_o",  32'(a_if.db_o),   32'hA5);
        chk("basic_drive_ack",   32'(a_if.wr_ack), 32'h0);
        tick();
        chk("basic_hold_rw_n",   32'(a_if.rw_n),   32'h1);
        chk("basic_hold_oe",     32'(a_if.db_oe),  32'h1);
        chk("basic_hold_ack",    32'(a_if.wr_ack), 32'h1);
        chk("basic_hold_busy",   32'(a_if.busy),   32'h1);
        tick();
        chk("basic_idle_busy",   32'(a_if.busy),   32'h0);
        chk("basic_idle_oe",     32'(a_if.db_oe),  32'h0);
        chk("basic_idle_ack",    32'(a_if.wr_ack), 32'h0);
        chk("basic_idle_db_o",   32'(a_if.db_o),   32'hA5);

        // Wait states: four rdy-low DRIVE edges, DRIVE lasts five cycles
        a_if.wr_di = 8'h77; a_if.wr_req = 1'b1; a_if.rdy = 1'b0;
        tick();
        a_if.wr_req = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("wait_drive_oe",   32'(a_if.db_oe),  32'h1);
            chk("wait_drive_rw_n", 32'(a_if.rw_n),   32'h0);
            chk("wait_drive_db_o", 32'(a_if.db_o),   32'h77);
            chk("wait_drive_ack",  32'(a_if.wr_ack), 32'h0);
            if (k == 4) a_if.rdy = 1'b1;
            tick();
        end
        chk("wait_hold_ack",  32'(a_if.wr_ack), 32'h1);
        chk("wait_hold_db_o", 32'(a_if.db_o),   32'h77);
        tick();
        chk("wait_idle_ack",  32'(a_if.wr_ack), 32'h0);
        chk("wait_idle_busy", 32'(a_if.busy),   32'h0);

        // Request held during a transfer is ignored, new data does not leak in
        a_if.wr_di = 8'h5A; a_if.wr_req = 1'b1; a_if.rdy = 1'b0;
        tick();
        a_if.wr_di = 8'h3C;
        tick();
        chk("ign_drive_db_o", 32'(a_if.db_o), 32'h5A);
        tick();
        chk("ign_stall_db_o", 32'(a_if.db_o), 32'h5A);
        a_if.rdy = 1'b1;
        tick();
        chk("ign_hold_ack",   32'(a_if.wr_ack), 32'h1);
        chk("ign_hold_db_o",  32'(a_if.db_o),   32'h5A);
        tick();
        chk("ign_idle_busy",  32'(a_if.busy), 32'h0);
        chk("ign_idle_db_o",  32'(a_if.db_o), 32'h5A);
        tick();
        a_if.wr_req = 1'b0;
        chk("ign_next_busy",  32'(a_if.busy), 32'h1);
        chk("ign_next_db_o",  32'(a_if.db_o), 32'h3C);
        tick(); tick(); tick();
        chk("ign_next_done",  32'(a_if.busy), 32'h0);

        // Asynchronous reset in the middle of DRIVE
        a_if.wr_di = 8'hC3; a_if.wr_req = 1'b1; a_if.rdy = 1'b0;
        tick();
        a_if.wr_req = 1'b0;
        tick();
        chk("mid_drive_oe", 32'(a_if.db_oe), 32'h1);
        #2;
        res_n = 1'b0;
        #1;
        chk("mid_rst_oe",   32'(a_if.db_oe),  32'h0);
        chk("mid_rst_rw_n", 32'(a_if.rw_n),   32'h1);
        chk("mid_rst_busy", 32'(a_if.busy),   32'h0);
        chk("mid_rst_db_o", 32'(a_if.db_o),   32'h00);
        chk("mid_rst_ack",  32'(a_if.wr_ack), 32'h0);
        tick();
        res_n = 1'b1;
        a_if.rdy = 1'b1;
        tick();
        chk("post_rst_ack",  32'(a_if.wr_ack), 32'h0);
        chk("post_rst_busy", 32'(a_if.busy),   32'h0);

        // Zero hold on instance b
        b_if.wr_di = 8'h96; b_if.wr_req = 1'b1; b_if.rdy = 1'b1;
        tick();
        b_if.wr_req = 1'b0;
        tick();
        chk("zh_drive_oe",   32'(b_if.db_oe),  32'h1);
        chk("zh_drive_rw_n", 32'(b_if.rw_n),   32'h0);
        tick();
        chk("zh_idle_ack",   32'(b_if.wr_ack), 32'h1);
        chk("zh_idle_oe",    32'(b_if.db_oe),  32'h0);
        chk("zh_idle_rw_n",  32'(b_if.rw_n),   32'h1);
        chk("zh_idle_busy",  32'(b_if.busy),   32'h0);
        chk("zh_idle_db_o",  32'(b_if.db_o),   32'h96);
        tick();
        chk("zh_ack_pulse",  32'(b_if.wr_ack), 32'h0);

`ifdef DBO_WDOG_EN
        // Watchdog abort after three rdy-low DRIVE edges
        b_if.wr_di = 8'h11; b_if.wr_req = 1'b1; b_if.rdy = 1'b0;
        tick();
        b_if.wr_req = 1'b0;
        tick();
        tick();
        chk("wd_c1_err",  32'(b_if.err),  32'h0);
        chk("wd_c1_busy", 32'(b_if.busy), 32'h1);
        tick();
        chk("wd_c2_err",  32'(b_if.err),  32'h0);
        chk("wd_c2_busy", 32'(b_if.busy), 32'h1);
        tick();
        chk("wd_abort_err",  32'(b_if.err),    32'h1);
        chk("wd_abort_ack",  32'(b_if.wr_ack), 32'h0);
        chk("wd_abort_busy", 32'(b_if.busy),   32'h0);
        chk("wd_abort_oe",   32'(b_if.db_oe),  32'h0);
        chk("wd_abort_rw_n", 32'(b_if.rw_n),   32'h1);
        tick();
        chk("wd_err_pulse",  32'(b_if.err),    32'h0);
        chk("wd_no_ack",     32'(b_if.wr_ack), 32'h0);

        // rdy rising on the edge the count would hit TIMEOUT completes normally
        b_if.wr_di = 8'h22; b_if.wr_req = 1'b1; b_if.rdy = 1'b0;
        tick();
        b_if.wr_req = 1'b0;
        tick();
        tick();
        tick();
        b_if.rdy = 1'b1;
        tick();
        chk("wd_race_ack",  32'(b_if.wr_ack), 32'h1);
        chk("wd_race_err",  32'(b_if.err),    32'h0);
        chk("wd_race_db_o", 32'(b_if.db_o),   32'h22);
`else
        // Without the watchdog DRIVE waits indefinitely and err stays low
        b_if.wr_di = 8'h11; b_if.wr_req = 1'b1; b_if.rdy = 1'b0;
        tick();
        b_if.wr_req = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("nowd_busy", 32'(b_if.busy),  32'h1);
            chk("nowd_oe",   32'(b_if.db_oe), 32'h1);
            chk("nowd_err",  32'(b_if.err),   32'h0);
        end
        b_if.rdy = 1'b1;
        tick();
        chk("nowd_ack",  32'(b_if.wr_ack), 32'h1);
        chk("nowd_err2", 32'(b_if.err),    32'h0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
